// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LDA = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_INC = 4'b0101;
    localparam logic [3:0] OP_CLA = 4'b0110;
    localparam logic [3:0] OP_CLE = 4'b0111;
    localparam logic [3:0] OP_INP = 4'b1000;
    localparam logic [3:0] OP_CMA = 4'b1001;
    localparam logic [3:0] OP_CME = 4'b1010;
    localparam logic [3:0] OP_CIR = 4'b1011;
    localparam logic [3:0] OP_CIL = 4'b1100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Rotates are the only opcodes that may run for more than one clock.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_CIR) || (op == OP_CIL);
    endfunction

endpackage

// File: rtl/alu_comb_datapath.sv
// Combinational next-state for AC/E given one opcode; also flags illegal codes.
// Latency: 0 (purely combinational).
// Backpressure: none; the caller decides when to commit the result.
module alu_comb_datapath
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int INPR_W = 8
) (
    input  logic [DATA_W-1:0] ac_in,
    input  logic              e_in,
    input  logic [DATA_W-1:0] dr_in,
    input  logic [INPR_W-1:0] inpr_in,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] ac_out,
    output logic              e_out,
    output logic              illegal
);

    // Every opcode starts from "hold", so illegal codes leave AC/E untouched.
    always_comb begin
        ac_out  = ac_in;
        e_out   = e_in;
        illegal = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_AND: ac_out = ac_in & dr_in;
            OP_ADD: {e_out, ac_out} = {1'b0, ac_in} + {1'b0, dr_in};
            OP_LDA: ac_out = dr_in;
            // Two's-complement subtract: carry out set means no borrow.
            OP_SUB: {e_out, ac_out} = {1'b0, ac_in} + {1'b0, ~dr_in} + (DATA_W+1)'(1);
            OP_INC: ac_out = ac_in + DATA_W'(1);
            OP_CLA: ac_out = '0;
            OP_CLE: e_out = 1'b0;
            OP_INP: ac_out[INPR_W-1:0] = inpr_in;
            OP_CMA: ac_out = ~ac_in;
            OP_CME: e_out = ~e_in;
            // Single-bit rotate of the {E,AC} ring; multi-bit rotates repeat this.
            OP_CIR: begin
                ac_out = {e_in, ac_in[DATA_W-1:1]};
                e_out  = ac_in[0];
            end
            OP_CIL: begin
                ac_out = {ac_in[DATA_W-2:0], e_in};
                e_out  = ac_in[DATA_W-1];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered AC/E ALU: one op per accepted start, rotates run one bit per clock.
// Latency: 1 clock for single-cycle ops, n clocks for a rotate by n (done follows last edge).
// Backpressure: busy high while a rotate is in flight; start is dropped (not queued) while busy.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int INPR_W  = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         alu_code,
    input  logic [DATA_W-1:0]  dr_outdata,
    input  logic [INPR_W-1:0]  inpr_outdata,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  ac_outdata,
    output logic               e_outdata,
    output logic               ac_zero,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e              state_q, state_d;
    logic [SHAMT_W-1:0]  count_q, count_d;
    logic                dir_cil_q, dir_cil_d;
    logic [DATA_W-1:0]   ac_q, ac_d;
    logic                e_q, e_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [3:0]          dp_op;
    logic [DATA_W-1:0]   dp_ac;
    logic                dp_e;
    logic                dp_illegal;
    logic [SHAMT_W-1:0]  extra_steps;

    // While shifting, the datapath is driven by the latched direction, not alu_code.
    always_comb begin
        dp_op = alu_code;
        if (state_q == ST_SHIFT) begin
            dp_op = dir_cil_q ? OP_CIL : OP_CIR;
        end
    end

    alu_comb_datapath #(
        .DATA_W (DATA_W),
        .INPR_W (INPR_W)
    ) u_datapath (
        .ac_in   (ac_q),
        .e_in    (e_q),
        .dr_in   (dr_outdata),
        .inpr_in (inpr_outdata),
        .opcode  (dp_op),
        .ac_out  (dp_ac),
        .e_out   (dp_e),
        .illegal (dp_illegal)
    );

    // Rotates still owed after the one done on the start edge (shamt 0 acts as 1).
    always_comb begin
        extra_steps = '0;
        if (shamt != '0) begin
            extra_steps = shamt - SHAMT_W'(1);
        end
    end

    // Next-state: accept in IDLE, step the rotate in SHIFT; done/err pulse by default low.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dir_cil_d = dir_cil_q;
        ac_d      = ac_q;
        e_d       = e_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ac_d  = dp_ac;
                    e_d   = dp_e;
                    err_d = dp_illegal;
                    if (is_shift_op(alu_code) && (extra_steps != '0)) begin
                        state_d   = ST_SHIFT;
                        count_d   = extra_steps;
                        dir_cil_d = (alu_code == OP_CIL);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                ac_d    = dp_ac;
                e_d     = dp_e;
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and architectural registers; reset abandons any rotate in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            dir_cil_q <= 1'b0;
            ac_q      <= '0;
            e_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dir_cil_q <= dir_cil_d;
            ac_q      <= ac_d;
            e_q       <= e_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ac_outdata = ac_q;
    assign e_outdata  = e_q;
    assign ac_zero    = (ac_q == '0);
    assign busy       = (state_q == ST_SHIFT);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: expected AC/E/err/latency queued at start, checked at done.
// Latency: n/a (testbench).
// Backpressure: bench only issues when the DUT is idle, except a deliberate start-while-busy.
module tb_alu_seq_unit;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    alu_code;
    logic [DW-1:0] dr_outdata;
    logic [IW-1:0] inpr_outdata;
    logic [SW-1:0] shamt;
    logic [DW-1:0] ac_outdata;
    logic          e_outdata;
    logic          ac_zero;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    alu_seq_unit #(
        .DATA_W  (DW),
        .INPR_W  (IW),
        .SHAMT_W (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .alu_code     (alu_code),
        .dr_outdata   (dr_outdata),
        .inpr_outdata (inpr_outdata),
        .shamt        (shamt),
        .ac_outdata   (ac_outdata),
        .e_outdata    (e_outdata),
        .ac_zero      (ac_zero),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    typedef struct {
        logic [DW-1:0] ac;
        logic          e;
        logic          err;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_x;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [DW-1:0] m_ac     = '0;
    logic          m_e      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: arithmetic via compare/subtract, rotates on a 17-bit ring.
    task automatic model_op(input logic [3:0] code, input logic [DW-1:0] d,
                            input logic [IW-1:0] inp, input logic [SW-1:0] sa,
                            output logic err_o, output int n_o);
        int unsigned    s;
        logic [DW:0]    ring;
        err_o = 1'b0;
        n_o   = 1;
        case (code)
            4'd0:  ;
            4'd1:  m_ac = m_ac & d;
            4'd2:  begin
                s    = 32'(m_ac) + 32'(d);
                m_e  = (s > 32'hFFFF);
                m_ac = s[DW-1:0];
            end
            4'd3:  m_ac = d;
            4'd4:  begin
                m_e  = (m_ac >= d);
                m_ac = m_ac - d;
            end
            4'd5:  m_ac = m_ac + 16'd1;
            4'd6:  m_ac = '0;
            4'd7:  m_e = 1'b0;
            4'd8:  m_ac[IW-1:0] = inp;
            4'd9:  m_ac = ~m_ac;
            4'd10: m_e = ~m_e;
            4'd11, 4'd12: begin
                n_o  = (sa == 0) ? 1 : int'(sa);
                ring = {m_e, m_ac};
                for (int i = 0; i < n_o; i++) begin
                    if (code == 4'd11) ring = {ring[0], ring[DW:1]};
                    else               ring = {ring[DW-1:0], ring[DW]};
                end
                m_e  = ring[DW];
                m_ac = ring[DW-1:0];
            end
            default: err_o = 1'b1;
        endcase
    endtask

    // Drive one start for a single edge and queue what the DUT must report.
    task automatic issue(input logic [3:0] code, input logic [DW-1:0] d,
                         input logic [IW-1:0] inp, input logic [SW-1:0] sa);
        exp_t x;
        logic er;
        int   n;
        model_op(code, d, inp, sa, er, n);
        x.ac  = m_ac;
        x.e   = m_e;
        x.err = er;
        x.due = cyc + n;
        sb.push_back(x);
        start        = 1'b1;
        alu_code     = code;
        dr_outdata   = d;
        inpr_outdata = inp;
        shamt        = sa;
        @(posedge clk);
        #1;
        start        = 1'b0;
        alu_code     = 4'($urandom_range(0, 15));
        dr_outdata   = DW'($urandom);
        inpr_outdata = IW'($urandom);
        shamt        = SW'($urandom);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || sb.size() != 0) && g < 64) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 64) chk("wait_idle_timeout", 32'(g), 32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_ac = '0;
        m_e  = 1'b0;
    endtask

    // Scoreboard monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) chk("err_needs_done", 32'(done), 32'd1);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    mon_x = sb.pop_front();
                    chk("sb_ac",      32'(ac_outdata), 32'(mon_x.ac));
                    chk("sb_e",       32'(e_outdata),  32'(mon_x.e));
                    chk("sb_err",     32'(err),        32'(mon_x.err));
                    chk("sb_latency", 32'(cyc),        32'(mon_x.due));
                    chk("sb_ac_zero", 32'(ac_zero),    32'(mon_x.ac == '0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        alu_code     = '0;
        dr_outdata   = '0;
        inpr_outdata = '0;
        shamt        = '0;
        apply_reset(2);

        // Random activity across all opcodes, then reset mid-rotate.
        for (int i = 0; i < 30; i++) begin
            issue(4'($urandom_range(0, 15)), DW'($urandom), IW'($urandom), SW'($urandom));
            wait_idle();
        end
        issue(4'd11, '0, '0, 4'd9);
        repeat (2) @(posedge clk);
        apply_reset(2);
        @(negedge clk);
        chk("rst_ac",      32'(ac_outdata), 32'h0);
        chk("rst_e",       32'(e_outdata),  32'h0);
        chk("rst_busy",    32'(busy),       32'h0);
        chk("rst_done",    32'(done),       32'h0);
        chk("rst_err",     32'(err),        32'h0);
        chk("rst_ac_zero", 32'(ac_zero),    32'h1);
        @(posedge clk);
        #1;

        // Back-to-back LDA then ADD overflowing into E.
        issue(4'd3, 16'hFFFF, '0, '0);
        issue(4'd2, 16'h0001, '0, '0);
        wait_idle();
        chk("add_ac",   32'(ac_outdata), 32'h0000);
        chk("add_e",    32'(e_outdata),  32'h1);
        chk("add_zero", 32'(ac_zero),    32'h1);

        // SUB with and without borrow.
        issue(4'd3, 16'h0005, '0, '0);
        issue(4'd4, 16'h0007, '0, '0);
        wait_idle();
        chk("sub_borrow_ac", 32'(ac_outdata), 32'hFFFE);
        chk("sub_borrow_e",  32'(e_outdata),  32'h0);
        issue(4'd3, 16'h0005, '0, '0);
        issue(4'd4, 16'h0005, '0, '0);
        wait_idle();
        chk("sub_equal_ac", 32'(ac_outdata), 32'h0000);
        chk("sub_equal_e",  32'(e_outdata),  32'h1);

        // CIL by 3, observed edge by edge.
        issue(4'd3, 16'h8001, '0, '0);
        issue(4'd7, '0, '0, '0);
        wait_idle();
        issue(4'd12, '0, '0, 4'd3);
        @(negedge clk);
        chk("cil_s1_ac",   32'(ac_outdata), 32'h0002);
        chk("cil_s1_e",    32'(e_outdata),  32'h1);
        chk("cil_s1_busy", 32'(busy),       32'h1);
        @(negedge clk);
        chk("cil_s2_ac",   32'(ac_outdata), 32'h0005);
        chk("cil_s2_e",    32'(e_outdata),  32'h0);
        chk("cil_s2_busy", 32'(busy),       32'h1);
        @(negedge clk);
        chk("cil_s3_ac",   32'(ac_outdata), 32'h000A);
        chk("cil_s3_e",    32'(e_outdata),  32'h0);
        chk("cil_s3_busy", 32'(busy),       32'h0);
        chk("cil_s3_done", 32'(done),       32'h1);
        wait_idle();

        // CIR with shamt 0 behaves as a single rotate.
        issue(4'd3, 16'h0001, '0, '0);
        issue(4'd7, '0, '0, '0);
        wait_idle();
        issue(4'd11, '0, '0, 4'd0);
        @(negedge clk);
        chk("cir0_ac",   32'(ac_outdata), 32'h0000);
        chk("cir0_e",    32'(e_outdata),  32'h1);
        chk("cir0_busy", 32'(busy),       32'h0);
        chk("cir0_done", 32'(done),       32'h1);
        wait_idle();

        // start during a long rotate is ignored.
        issue(4'd3, 16'hA5C3, '0, '0);
        issue(4'd7, '0, '0, '0);
        wait_idle();
        issue(4'd11, '0, '0, 4'd15);
        start      = 1'b1;
        alu_code   = 4'd3;
        dr_outdata = 16'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk("cir15_ac", 32'(ac_outdata), 32'h970D);
        chk("cir15_e",  32'(e_outdata),  32'h0);

        // Reset on the fifth rotate edge abandons the shift with no done.
        issue(4'd11, '0, '0, 4'd15);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        apply_reset(1);
        @(negedge clk);
        chk("midrst_ac",   32'(ac_outdata), 32'h0);
        chk("midrst_e",    32'(e_outdata),  32'h0);
        chk("midrst_busy", 32'(busy),       32'h0);
        chk("midrst_done", 32'(done),       32'h0);
        repeat (20) @(negedge clk);

        // INP touches only the low byte; illegal code pulses err once.
        @(posedge clk);
        #1;
        issue(4'd3, 16'h1234, '0, '0);
        issue(4'd8, '0, 8'hAB, '0);
        wait_idle();
        chk("inp_ac", 32'(ac_outdata), 32'h12AB);
        issue(4'hF, 16'hFFFF, 8'hFF, '0);
        @(negedge clk);
        chk("illegal_done", 32'(done),       32'h1);
        chk("illegal_err",  32'(err),        32'h1);
        chk("illegal_ac",   32'(ac_outdata), 32'h12AB);
        @(negedge clk);
        chk("illegal_done_drop", 32'(done), 32'h0);
        chk("illegal_err_drop",  32'(err),  32'h0);

        // AC/E hold while start stays low despite changing inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ac", 32'(ac_outdata), 32'(m_ac));
            chk("hold_e",  32'(e_outdata),  32'(m_e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Parametrised, registered successor to the basic-computer ALU. It owns the AC and E registers and executes one operation per `start` pulse. Single-cycle ops complete in 1 clock. Circular shifts rotate through E by a programmable amount, one bit per clock, with busy/done handshake back to the control sequencer.

Parameters:
- `DATA_W`, 16: AC/DR width; must be ≥ INPR_W.
- `INPR_W`, 8: input-register width, loaded into AC[INPR_W-1:0] by INP.
- `SHAMT_W`, 4: width of the shift-amount field.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only when busy=0.
- `alu_code` in 4: operation select, sampled with start.
- `dr_outdata` in DATA_W: DR operand, sampled with start.
- `inpr_outdata` in INPR_W: INPR operand, sampled with start.
- `shamt` in SHAMT_W: rotate count for CIR/CIL, sampled with start; 0 treated as 1.
- `ac_outdata` out DATA_W: AC register.
- `e_outdata` out 1: E flag register.
- `ac_zero` out 1: combinational, (ac_outdata == 0).
- `busy` out 1: multi-cycle shift in progress.
- `done` out 1: one-cycle pulse, operation complete.
- `err` out 1: one-cycle pulse with done, illegal alu_code.

Behaviour:
- Reset (rst=1 at edge): AC=0, E=0, busy=0, done=0, err=0, state=IDLE, count=0. rst dominates every other input, including mid-shift; a shift in progress is abandoned with no done.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge k: the op executes at edge k. done=1 and err as required during cycle k+1, except for shifts with count>1.
- done/err default to 0 on every edge not listed.
- Opcodes (A=AC, D=DR; all arithmetic modulo 2^DATA_W):
  - 0000 NOP: no change; done only.
  - 0001 AND: A = A & D.
  - 0010 ADD: {E,A} = A + D (DATA_W+1-bit sum; E = carry out).
  - 0011 LDA: A = D.
  - 0100 SUB: {E,A} = A + ~D + 1; E=1 means no borrow.
  - 0101 INC: A = A + 1; E unchanged.
  - 0110 CLA: A = 0.
  - 0111 CLE: E = 0.
  - 1000 INP: A[INPR_W-1:0] = INPR; upper bits unchanged.
  - 1001 CMA: A = ~A.
  - 1010 CME: E = ~E.
  - 1011 CIR: rotate the DATA_W+1 ring {E,A} right: A = {E, A[DATA_W-1:1]}, E = A[0].
  - 1100 CIL: rotate left: A = {A[DATA_W-2:0], E}, E = A[DATA_W-1].
  - 1101–1111: illegal. No register change; done=1 and err=1 for one cycle.
- Shifts:
  - n = (shamt==0) ? 1 : shamt.
  - The first rotate happens at start edge k.
  - If n=1: identical timing to single-cycle ops.
  - Else: state=SHIFT, busy=1, count=n-1, direction latched. Each following edge rotates once and decrements count.
  - The edge performing the last rotate sets state=IDLE and busy=0; done=1 in the following cycle.
  - Total latency n edges; busy high for n-1 cycles.
- start while busy=1 is ignored entirely; no queueing.
- start is accepted in the same cycle that done is high, giving back-to-back throughput of 1 op/clock.
- AC and E are never modified outside an accepted op or reset.
- alu_code and operands are don't-care when start=0.

Decomposition:
- Package `alu_pkg`: opcode localparams (`OP_NOP` … `OP_CIL`), state encoding (`ST_IDLE`, `ST_SHIFT`).
- One sub-module, `alu_comb_datapath`: purely combinational.
  - Inputs: AC, E, DR, INPR, opcode.
  - Outputs: next AC, next E, illegal flag.
  - Used for single-cycle ops and for each shift step.
- The top level holds the registers, FSM, counter and handshake.

Test Plan (DATA_W=16, INPR_W=8, SHAMT_W=4):
1. Reset: rst=1 for 2 clocks after random activity → AC=0x0000, E=0, busy=0, done=0, err=0, ac_zero=1.
2. LDA D=0xFFFF, then ADD D=0x0001 → AC=0x0000, E=1, ac_zero=1; each op gives done one cycle after start; back-to-back starts are both accepted.
3. LDA 0x0005, then SUB D=0x0007 → AC=0xFFFE, E=0. Then SUB D=0x0005 from 0x0005 → AC=0x0000, E=1.
4. AC=0x8001, E=0, CIL shamt=3 → per edge:
   - AC=0x0002, E=1
   - AC=0x0005, E=0
   - AC=0x000A, E=0
   busy high 2 cycles, done after 3rd edge. CIR shamt=0 from AC=0x0001, E=0 → AC=0x0000, E=1 in 1 cycle.
5. During a CIR shamt=15, pulse start with LDA → ignored, shift completes unaltered. Repeat with rst=1 at the 5th shift edge → AC=0, E=0, busy=0, no done.
6. AC=0x1234, INP INPR=0xAB → AC=0x12AB. alu_code=0xF → AC/E unchanged, done=1 and err=1 for exactly one cycle.
